// File: rtl/regfile_wb_sched_if.sv
// Writeback, issue and register-file write-port signals of the writeback scheduler.
// The slave modport is the scheduler's view of the bus.
interface regfile_wb_sched_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_reg;
  logic [XLEN-1:0] wb0_data;
  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_reg;
  logic [XLEN-1:0] wb1_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_reg;
  logic            issue_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic            flush;
  logic            busy_any;
  logic            reg_write;
  logic [AW-1:0]   w_reg;
  logic [XLEN-1:0] w_data;

  modport master (
    output wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
           issue_valid, issue_reg, rs1, rs2, flush,
    input  wb0_ready, wb1_ready, issue_ready, hazard_rs1, hazard_rs2,
           busy_any, reg_write, w_reg, w_data
  );

  modport slave (
    input  wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
           issue_valid, issue_reg, rs1, rs2, flush,
    output wb0_ready, wb1_ready, issue_ready, hazard_rs1, hazard_rs2,
           busy_any, reg_write, w_reg, w_data
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin merge of two writeback channels onto the
// register-file write port, plus a busy scoreboard driving issue stalls and hazards.
module regfile_wb_sched #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_sched_if.slave   bus
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            prio_q, prio_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   w_reg_q, w_reg_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic grant0, grant1, issue_fire;

  // prio points at the channel that wins the next contested cycle
  always_comb begin
    grant0 = bus.wb0_valid & (~bus.wb1_valid | ~prio_q);
    grant1 = bus.wb1_valid & (~bus.wb0_valid |  prio_q);
    prio_d = prio_q ^ (bus.wb0_valid & bus.wb1_valid);
  end

  always_comb begin
    reg_write_d = 1'b0;
    w_reg_d     = w_reg_q;
    w_data_d    = w_data_q;
    if (grant0) begin
      reg_write_d = (bus.wb0_reg != AW'(0));
      w_reg_d     = bus.wb0_reg;
      w_data_d    = bus.wb0_data;
    end else if (grant1) begin
      reg_write_d = (bus.wb1_reg != AW'(0));
      w_reg_d     = bus.wb1_reg;
      w_data_d    = bus.wb1_data;
    end
  end

  // Clear on commit, set on issue (set wins), flush wins over both
  always_comb begin
    issue_fire = bus.issue_valid & bus.issue_ready & (bus.issue_reg != AW'(0));
    busy_d     = busy_q;
    if (reg_write_q) busy_d[w_reg_q] = 1'b0;
    if (issue_fire)  busy_d[bus.issue_reg] = 1'b1;
    if (bus.flush)   busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      prio_q      <= 1'b0;
      reg_write_q <= 1'b0;
      w_reg_q     <= '0;
      w_data_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      prio_q      <= prio_d;
      reg_write_q <= reg_write_d;
      w_reg_q     <= w_reg_d;
      w_data_q    <= w_data_d;
    end
  end

  assign bus.wb0_ready   = grant0;
  assign bus.wb1_ready   = grant1;
  assign bus.issue_ready = ~busy_q[bus.issue_reg] | (bus.issue_reg == AW'(0));
  assign bus.hazard_rs1  = busy_q[bus.rs1] & (bus.rs1 != AW'(0));
  assign bus.hazard_rs2  = busy_q[bus.rs2] & (bus.rs2 != AW'(0));
  assign bus.busy_any    = |busy_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.w_reg       = w_reg_q;
  assign bus.w_data      = w_data_q;

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Writeback scheduler and scoreboard for the 64-bit, 32-entry integer register file. Two writeback sources share the file's single write port:
- channel 0: single-cycle ALU result path
- channel 1: multi-cycle load/mul/div unit

The block round-robin arbitrates them into a registered write-port drive (reg_write/w_reg/w_data). It also tracks registers with outstanding writes and flags read-after-write and write-after-write hazards to the issue stage.

Parameters:
XLEN, 64, data width of register file and writeback channels
NREG, 32, number of architectural registers; x0 hardwired zero
AW, 5, register index width, log2(NREG)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
wb0_valid  input  1  channel 0 writeback request
wb0_ready  output  1  channel 0 accepted this cycle
wb0_reg  input  AW  channel 0 destination register
wb0_data  input  XLEN  channel 0 result
wb1_valid  input  1  channel 1 writeback request
wb1_ready  output  1  channel 1 accepted this cycle
wb1_reg  input  AW  channel 1 destination register
wb1_data  input  XLEN  channel 1 result
issue_valid  input  1  issue stage dispatching an instruction with destination
issue_reg  input  AW  destination register of issuing instruction
issue_ready  output  1  destination free; dispatch may proceed
rs1, rs2  input  AW each  source registers of instruction in issue
hazard_rs1, hazard_rs2  output  1 each  source has a pending write
flush  input  1  synchronous pipeline flush
busy_any  output  1  any register has a pending write
reg_write  output  1  register file write enable (registered)
w_reg  output  AW  register file write index (registered)
w_data  output  XLEN  register file write data (registered)

Behaviour:
- Reset (reset=0, async): busy[NREG-1:0]=0, prio=0, reg_write=0, w_reg=0, w_data=0. Combinational outputs follow from cleared state: issue_ready=1, hazards=0, busy_any=0, readies=0 unless valid.
- Arbitration (combinational, same cycle):
  - Only one valid: that channel is granted.
  - Both valid: channel prio is granted.
  - None valid: no grant.
  - wbN_ready = grant N. No other backpressure; the write port accepts every cycle.
  - Readies depend combinationally on both valids; sources must not make valid depend on ready.
- prio register: toggles only on a cycle where both channels are valid (points to the loser). Otherwise unchanged.
- Output stage, 1-cycle latency:
  - On handshake at edge T, load w_reg=granted reg and w_data=granted data.
  - reg_write = 1 if the granted reg != 0, else 0. A write to x0 completes its handshake but never asserts reg_write.
  - With no handshake, reg_write=0; w_reg/w_data hold their previous values.
  - The register file commits at edge T+1.
- Scoreboard:
  - Set: busy[issue_reg] is set at the edge where issue_valid & issue_ready & issue_reg!=0.
  - issue_ready = !busy[issue_reg] | (issue_reg==0). At most one outstanding write per register (WAW stall).
  - Clear: busy[w_reg] is cleared at the edge where reg_write=1, i.e. when the file actually commits.
  - Set and clear of the same register on the same edge: set wins, bit stays 1.
  - busy[0] is never set.
- Hazards:
  - hazard_rsN = busy[rsN] & (rsN!=0).
  - The clear is coincident with the commit, so a register whose commit occurs at edge E reads hazard-free and correct after E. No bypass.
- busy_any = |busy.
- flush=1: all busy bits clear at the next edge, taking priority over a simultaneous set. Arbitration, handshakes and the output stage are unaffected; in-flight writebacks still commit.
- Reset mid-operation: state clears immediately. A pending registered write is dropped; reg_write falls asynchronously.
- Writebacks to non-busy registers are legal and commit normally; the clear is a no-op.

Test Plan:
- Reset, then wb0_valid=1, wb0_reg=5, wb0_data=0xDEAD_BEEF for one cycle -> wb0_ready=1 that cycle; next cycle reg_write=1, w_reg=5, w_data=0xDEADBEEF; following cycle reg_write=0.
- Both channels valid for 4 consecutive cycles (regs 1 and 2) -> grants alternate 0,1,0,1; reg_write high 4 consecutive cycles with w_reg 1,2,1,2.
- issue_valid with issue_reg=7 -> next cycle hazard_rs1=1 for rs1=7, issue_ready=0 for issue_reg=7, busy_any=1. wb1 writes reg 7 -> hazard stays 1 during the reg_write cycle and drops to 0 after that edge.
- wb0 write to reg 0 with data 0x1234 -> wb0_ready=1, reg_write stays 0. issue_reg=0 -> issue_ready=1, busy unchanged, hazard for rs1=0 always 0.
- Same edge: reg_write=1 for w_reg=9 and a new issue to reg 9 -> busy[9] remains 1. Then flush=1 with an issue to reg 3 -> busy_any=0 next cycle.
- Assert reset low mid-stream with reg_write=1 and busy bits set -> reg_write, busy_any and hazards go 0 without waiting for a clock edge; prio=0 after release (both valid grants channel 0).
